// File: rtl/pp_fifo_wr_arb.sv
// Round-robin write arbiter for a push/pop FIFO with a flush sequencer
// (block producers, optional drain, one-cycle clear pulse, done pulse).
module pp_fifo_wr_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_push,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic                            fifo_clear,
  input  logic                            fifo_pop,
  input  logic                            fifo_empty,
  input  logic                            fifo_full,
  input  logic                            flush_req,
  input  logic                            flush_wait,
  output logic                            flush_done,
  output logic [$clog2(NUM_REQ)-1:0]      last_grant,
  output logic [15:0]                     push_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (CNT_W < 1)) begin : g_bad_param
    $error("pp_fifo_wr_arb: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, BLOCK, DRAIN, CLEAR, DONE} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] next_ptr;
  logic             any_valid;
  logic             can_push;
  logic             push;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner    = rr_ptr;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && req_valid[wrap_add(rr_ptr, k)]) begin
        winner    = wrap_add(rr_ptr, k);
        any_valid = 1'b1;
      end
    end
  end

  assign next_ptr  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
  assign can_push  = ~fifo_full | (fifo_pop & ~fifo_empty);
  assign push      = reset_n & (state == IDLE) & can_push & any_valid;
  assign fifo_push = push;
  assign req_ready = push ? (NUM_REQ'(1) << winner) : '0;
  assign fifo_data = reset_n ? req_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // fifo_clear/flush_done are set on entry to CLEAR/DONE so each is high for exactly that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      last_grant <= '0;
      push_cnt   <= '0;
      fifo_clear <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      fifo_clear <= 1'b0;
      flush_done <= 1'b0;
      if (push) begin
        rr_ptr     <= next_ptr;
        last_grant <= winner;
        push_cnt   <= push_cnt + 16'd1;
      end
      unique case (state)
        IDLE:  if (flush_req) state <= BLOCK;
        BLOCK: begin
          if (flush_wait) begin
            state <= DRAIN;
          end else begin
            state      <= CLEAR;
            fifo_clear <= 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state      <= CLEAR;
            fifo_clear <= 1'b1;
          end
        end
        CLEAR: begin
          state      <= DONE;
          flush_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
